// File: rtl/mlp_pkg.sv
// Shared types and fixed-point helpers for the fully-connected layer engine.
// Helper widths are passed as arguments so every instance can use its own DW/FRAC/ACC_W.
package mlp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_X = 2'd1,
    RUN    = 2'd2,
    FIN    = 2'd3
  } state_e;

  // clog2 that never yields a zero-width counter.
  function automatic int cw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Keep the product's sign bit plus the DW-1 bits just above the binary point.
  function automatic logic signed [63:0] trunc(input logic signed [63:0] p,
                                               input int dw, input int frac);
    logic signed [63:0] s;
    logic signed [63:0] r;
    s = p >>> frac;
    r = '0;
    for (int i = 0; i < 64; i++) r[i] = (i < dw - 1) ? s[i] : p[63];
    return r;
  endfunction

  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int acc_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/mlp_layer_engine_lane_dot.sv
// Combinational lane dot product: LANES signed multipliers, per-lane truncation
// back to the element format, and a sum across lanes.
module mlp_lane_dot
  import mlp_pkg::*;
#(
  parameter int DW    = 8,
  parameter int FRAC  = 5,
  parameter int LANES = 4,
  parameter int SUM_W = DW + cw(LANES)
) (
  input  logic [LANES*DW-1:0]     x,
  input  logic [LANES*DW-1:0]     w,
  output logic signed [SUM_W-1:0] lanesum
);

  logic signed [2*DW-1:0] prod_p0 [LANES];
  logic signed [63:0]     sum_p0;

  always_comb begin
    sum_p0 = '0;
    for (int k = 0; k < LANES; k++) begin
      prod_p0[k] = $signed(x[k*DW +: DW]) * $signed(w[k*DW +: DW]);
      sum_p0     = sum_p0 + trunc(64'(prod_p0[k]), DW, FRAC);
    end
    lanesum = SUM_W'(sum_p0);
  end

endmodule

// File: rtl/mlp_layer_engine.sv
// Fully-connected layer engine: buffers one input vector, streams neuron-major
// weights LANES per cycle, emits saturated (optionally ReLU'd) results and an argmax.
module mlp_layer_engine
  import mlp_pkg::*;
#(
  parameter int DW    = 8,
  parameter int FRAC  = 5,
  parameter int LANES = 4,
  parameter int N_IN  = 784,
  parameter int N_OUT = 30,
  parameter int ACC_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_b,
  input  logic                      start,
  input  logic                      reuse_x,
  input  logic                      relu_en,
  input  logic                      x_valid,
  output logic                      x_ready,
  input  logic [LANES*DW-1:0]       x_data,
  input  logic                      w_valid,
  output logic                      w_ready,
  input  logic [LANES*DW-1:0]       w_data,
  input  logic signed [DW-1:0]      b_data,
  output logic                      y_valid,
  input  logic                      y_ready,
  output logic signed [ACC_W-1:0]   y_data,
  output logic [cw(N_OUT)-1:0]      y_idx,
  output logic                      y_last,
  output logic                      busy,
  output logic                      done,
  output logic [cw(N_OUT)-1:0]      max_idx,
  output logic signed [ACC_W-1:0]   max_val
);

  localparam int BEATS = N_IN / LANES;
  localparam int BW    = cw(BEATS);
  localparam int IW    = cw(N_OUT);
  localparam int SUM_W = DW + cw(LANES);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [IW-1:0] LAST_N    = IW'(N_OUT - 1);

  state_e state, state_nxt;

  logic [LANES*DW-1:0]      xbuf [BEATS];
  logic [BW-1:0]            beat;
  logic [IW-1:0]            neuron;
  logic                     relu_r;
  logic signed [ACC_W-1:0]  acc_p1;
  logic signed [SUM_W-1:0]  lanesum_p0;
  logic signed [63:0]       acc_base_p0;
  logic signed [ACC_W-1:0]  acc_nxt_p0;
  logic signed [ACC_W-1:0]  res_p0;
  logic [IW-1:0]            run_idx;
  logic signed [ACC_W-1:0]  run_val;
  logic                     x_hs, w_hs, y_hs, first_beat, last_beat;

  assign x_hs       = x_valid & x_ready;
  assign w_hs       = w_valid & w_ready;
  assign y_hs       = y_valid & y_ready;
  assign first_beat = (beat == '0);
  assign last_beat  = (beat == LAST_BEAT);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = reuse_x ? RUN : LOAD_X;
      LOAD_X:  if (x_hs && last_beat) state_nxt = RUN;
      RUN:     if (y_hs && y_last) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A pending, unaccepted result stalls the weight stream.
  always_comb begin
    x_ready = 1'b0;
    w_ready = 1'b0;
    busy    = (state != IDLE);
    done    = (state == FIN);
    case (state)
      LOAD_X:  x_ready = 1'b1;
      RUN:     w_ready = !(y_valid && !y_ready);
      default: ;
    endcase
  end

  // The input vector is plain storage; its contents are meaningless after reset.
  always_ff @(posedge clk) begin
    if (x_hs) xbuf[beat] <= x_data;
  end

  // ---- p0: lane products and accumulate (bias replaces acc on beat 0) ----
  mlp_lane_dot #(.DW(DW), .FRAC(FRAC), .LANES(LANES), .SUM_W(SUM_W)) u_dot (
    .x       (xbuf[beat]),
    .w       (w_data),
    .lanesum (lanesum_p0)
  );

  always_comb begin
    acc_base_p0 = first_beat ? 64'(b_data) : 64'(acc_p1);
    acc_nxt_p0  = ACC_W'(sat(acc_base_p0 + 64'(lanesum_p0), ACC_W));
    res_p0      = (relu_r && acc_nxt_p0[ACC_W-1]) ? '0 : acc_nxt_p0;
  end

  // ---- p1: accumulator, result register and argmax ----
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      beat    <= '0;
      neuron  <= '0;
      relu_r  <= 1'b0;
      acc_p1  <= '0;
      y_valid <= 1'b0;
      y_data  <= '0;
      y_idx   <= '0;
      y_last  <= 1'b0;
      run_idx <= '0;
      run_val <= '0;
      max_idx <= '0;
      max_val <= '0;
    end else begin
      if (state == IDLE && start) begin
        relu_r <= relu_en;
        neuron <= '0;
        beat   <= '0;
      end
      if (x_hs || w_hs) beat <= last_beat ? '0 : beat + BW'(1);
      if (w_hs) begin
        acc_p1 <= acc_nxt_p0;
        if (last_beat) neuron <= (neuron == LAST_N) ? '0 : neuron + IW'(1);
      end
      if (w_hs && last_beat) begin
        y_valid <= 1'b1;
        y_data  <= res_p0;
        y_idx   <= neuron;
        y_last  <= (neuron == LAST_N);
      end else if (y_hs) begin
        y_valid <= 1'b0;
      end
      // Strictly-greater keeps the lowest index on ties; neuron 0 seeds the pass.
      if (y_hs && (y_idx == '0 || y_data > run_val)) begin
        run_idx <= y_idx;
        run_val <= y_data;
      end
      if (state == FIN) begin
        max_idx <= run_idx;
        max_val <= run_val;
      end
    end
  end

endmodule
